// File: rtl/cic_decimator_pkg.sv
// cic_decimator_pkg
//   Shared definitions for the CIC decimation chain: the ceiling-log2 helper
//   used to size the counter and the full-precision datapath, plus the
//   default parameter values of the decimator.
package cic_decimator_pkg;

  localparam int CIC_IN_WIDTH_DEF  = 2;
  localparam int CIC_OUT_WIDTH_DEF = 16;
  localparam int CIC_N_DEF         = 4;
  localparam int CIC_R_DEF         = 64;

  // Ceiling log2; exact for the power-of-two ratios this chain uses.
  function automatic int clog2(input int value);
    int result;
    int v;
    result = 0;
    v      = value - 1;
    while (v > 0) begin
      result = result + 1;
      v      = v >> 1;
    end
    return result;
  endfunction

  // Full-precision register width: Hogenauer bit growth for M=1.
  function automatic int cic_w_full(input int in_width, input int n, input int r);
    return in_width + n * clog2(r);
  endfunction

endpackage

// File: rtl/cic_decimator_comb_stage.sv
// cic_comb_stage
//   One comb section of the decimator running at the decimated rate:
//   c_out = c_in - D, and D takes c_in on each decimation strobe.
//   Ports:
//     clk    in   system clock
//     reset  in   asynchronous active-low reset, clears the delay register
//     dec    in   decimation strobe (delay register advances)
//     c_in   in   W-bit stage input (combinational from previous stage)
//     c_out  out  W-bit stage output, modulo 2^W
module cic_comb_stage #(
  parameter int W = 26
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         dec,
  input  logic [W-1:0] c_in,
  output logic [W-1:0] c_out
);

  logic [W-1:0] dly_q;
  logic [W-1:0] dly_d;

  always_comb begin
    dly_d = dly_q;
    if (dec) begin
      dly_d = c_in;
    end
  end

  assign c_out = c_in - dly_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      dly_q <= '0;
    end else begin
      dly_q <= dly_d;
    end
  end

endmodule

// File: rtl/cic_decimator.sv
// cic_decimator
//   Hogenauer CIC decimator: N pipelined integrators at the input rate,
//   decimation by R, N combs at the output rate (differential delay 1).
//   The output is the top OUT_WIDTH bits of the full-precision comb result.
//   Ports:
//     clk         in   system clock, rising edge
//     reset       in   asynchronous active-low reset, clears all state
//     clk_enable  in   input sample valid; only enabled cycles advance the filter
//     filter_in   in   IN_WIDTH signed input sample
//     filter_out  out  OUT_WIDTH signed decimated sample, held between updates
//     ce_out      out  one-clock pulse, high the cycle after filter_out updates
module cic_decimator
  import cic_decimator_pkg::*;
#(
  parameter int IN_WIDTH  = CIC_IN_WIDTH_DEF,
  parameter int OUT_WIDTH = CIC_OUT_WIDTH_DEF,
  parameter int N         = CIC_N_DEF,
  parameter int R         = CIC_R_DEF
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 clk_enable,
  input  logic [IN_WIDTH-1:0]  filter_in,
  output logic [OUT_WIDTH-1:0] filter_out,
  output logic                 ce_out
);

  localparam int W_FULL = cic_w_full(IN_WIDTH, N, R);
  localparam int CNT_W  = clog2(R);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(R - 1);

  logic [W_FULL-1:0]    integ_q [N];
  logic [W_FULL-1:0]    integ_d [N];
  logic [CNT_W-1:0]     cnt_q;
  logic [CNT_W-1:0]     cnt_d;
  logic [OUT_WIDTH-1:0] filter_out_q;
  logic [OUT_WIDTH-1:0] filter_out_d;
  logic                 ce_out_q;
  logic                 ce_out_d;

  logic                 dec;
  logic [W_FULL-1:0]    in_sext;
  logic [W_FULL-1:0]    comb_c [N+1];

  assign in_sext = {{(W_FULL-IN_WIDTH){filter_in[IN_WIDTH-1]}}, filter_in};
  assign dec     = clk_enable && (cnt_q == CNT_LAST);

  // Each integrator adds the pre-edge value of its predecessor, giving a
  // one-cycle pipeline per stage; the wrap of the modulo adders cancels
  // exactly in the combs.
  always_comb begin
    for (int j = 0; j < N; j++) begin
      integ_d[j] = integ_q[j];
    end
    cnt_d = cnt_q;
    if (clk_enable) begin
      integ_d[0] = integ_q[0] + in_sext;
      for (int j = 1; j < N; j++) begin
        integ_d[j] = integ_q[j] + integ_q[j-1];
      end
      cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + 1'b1;
    end
  end

  assign comb_c[0] = integ_q[N-1];

  for (genvar g = 0; g < N; g++) begin : g_comb
    cic_comb_stage #(
      .W (W_FULL)
    ) u_comb (
      .clk   (clk),
      .reset (reset),
      .dec   (dec),
      .c_in  (comb_c[g]),
      .c_out (comb_c[g+1])
    );
  end

  always_comb begin
    filter_out_d = filter_out_q;
    ce_out_d     = dec;
    if (dec) begin
      filter_out_d = comb_c[N][W_FULL-1 -: OUT_WIDTH];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int j = 0; j < N; j++) begin
        integ_q[j] <= '0;
      end
      cnt_q        <= '0;
      filter_out_q <= '0;
      ce_out_q     <= 1'b0;
    end else begin
      for (int j = 0; j < N; j++) begin
        integ_q[j] <= integ_d[j];
      end
      cnt_q        <= cnt_d;
      filter_out_q <= filter_out_d;
      ce_out_q     <= ce_out_d;
    end
  end

  assign filter_out = filter_out_q;
  assign ce_out     = ce_out_q;

endmodule
